// File: rtl/decryption.sv
// Iterative MacGuffin block decryptor: one reverse round per clock, keys read
// combinationally from the shared round-key bus, AXI-Stream in and out.
module decryption #(
  parameter int ROUNDS = 32,
  parameter int KEY_W  = 48
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [63:0]                    s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [63:0]                    m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  input  logic [ROUNDS-1:0][KEY_W-1:0]   round_keys,
  input  logic                           key_ready
);

  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  // 6-in/2-out S-boxes shared with the encryptor; entry x of box j is {SB_HI[j][x], SB_LO[j][x]}
  localparam logic [63:0] SB_LO [8] = '{
    64'hD3A5_96C3_3C69_5A0F, 64'h4B1E_E187_78D2_2D69, 64'h96F0_0F96_A55A_C33C,
    64'h2DB4_B42D_D24B_4BD2, 64'h87E1_1E78_69A5_F00F, 64'h5AC3_3C5A_A53C_C3A5,
    64'hE14B_B41E_1EB4_4BE1, 64'h3C96_693C_C369_96C3
  };
  localparam logic [63:0] SB_HI [8] = '{
    64'h6996_C33C_A55A_0FF0, 64'hB44B_2DD2_E11E_8778, 64'h0FF0_6996_3CC3_5AA5,
    64'hD22D_4BB4_1EE1_7887, 64'hA55A_F00F_9669_3CC3, 64'h3CC3_A55A_0FF0_6996,
    64'h4BB4_E11E_D22D_1EE1, 64'hC33C_9669_5AA5_F00F
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   data_q, data_d;
  logic [63:0]   round_s;

  function automatic logic [1:0] sbox(input int j, input logic [5:0] x);
    sbox = {SB_HI[j][x], SB_LO[j][x]};
  endfunction

  // Each box takes two key-mixed bits from each of the three input words
  function automatic logic [15:0] f_round(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [47:0] k);
    logic [15:0] ka, kb, kc;
    logic [5:0]  x;
    ka = a ^ k[47:32];
    kb = b ^ k[31:16];
    kc = c ^ k[15:0];
    f_round = 16'd0;
    for (int j = 0; j < 8; j++) begin
      x = {ka[2*j+1], ka[2*j], kb[(2*j+5)%16], kb[(2*j+4)%16],
           kc[(2*j+11)%16], kc[(2*j+10)%16]};
      f_round[2*j +: 2] = sbox(j, x);
    end
  endfunction

  assign round_s = {data_q[15:0] ^ f_round(data_q[63:48], data_q[47:32], data_q[31:16],
                                           round_keys[cnt_q][47:0]),
                    data_q[63:16]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= LAST;
      data_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid && key_ready) begin
          data_d  = s_axis_tdata;
          cnt_d   = LAST;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Losing the keys mid-block makes the partial result meaningless
        if (!key_ready) begin
          cnt_d   = LAST;
          state_d = IDLE;
        end else if (cnt_q == {CW{1'b0}}) begin
          data_d  = round_s;
          cnt_d   = LAST;
          state_d = OUT;
        end else begin
          data_d  = round_s;
          cnt_d   = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          state_d = RUN;
        end
      end
      OUT: begin
        if (m_axis_tready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = LAST;
      end
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 64'd0;
    case (state_q)
      IDLE: s_axis_tready = key_ready & rst;
      OUT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = data_q;
      end
      default: s_axis_tready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_decryption.sv
// Directed bench: ciphertexts come from a forward-cipher model, the decryptor
// must return the original plaintext with fixed latency and clean handshakes.
module tb_decryption;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [63:0]          s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic [63:0]          m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [31:0][47:0]    round_keys;
  logic                 key_ready;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] SB_LO [8] = '{
    64'hD3A5_96C3_3C69_5A0F, 64'h4B1E_E187_78D2_2D69, 64'h96F0_0F96_A55A_C33C,
    64'h2DB4_B42D_D24B_4BD2, 64'h87E1_1E78_69A5_F00F, 64'h5AC3_3C5A_A53C_C3A5,
    64'hE14B_B41E_1EB4_4BE1, 64'h3C96_693C_C369_96C3
  };
  localparam logic [63:0] SB_HI [8] = '{
    64'h6996_C33C_A55A_0FF0, 64'hB44B_2DD2_E11E_8778, 64'h0FF0_6996_3CC3_5AA5,
    64'hD22D_4BB4_1EE1_7887, 64'hA55A_F00F_9669_3CC3, 64'h3CC3_A55A_0FF0_6996,
    64'h4BB4_E11E_D22D_1EE1, 64'hC33C_9669_5AA5_F00F
  };

  decryption #(.ROUNDS(32), .KEY_W(48)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .round_keys(round_keys), .key_ready(key_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f_model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [47:0] k);
    logic [15:0] ka, kb, kc, r;
    logic [5:0]  x;
    ka = a ^ k[47:32];
    kb = b ^ k[31:16];
    kc = c ^ k[15:0];
    r = 16'd0;
    for (int j = 0; j < 8; j++) begin
      x = {ka[2*j+1], ka[2*j], kb[(2*j+5)%16], kb[(2*j+4)%16],
           kc[(2*j+11)%16], kc[(2*j+10)%16]};
      r[2*j]   = SB_LO[j][x];
      r[2*j+1] = SB_HI[j][x];
    end
    return r;
  endfunction

  // Forward cipher: (W0,W1,W2,W3) -> (W1,W2,W3,W0^F(W1,W2,W3,k[i])), i = 0..31
  function automatic logic [63:0] encrypt(input logic [63:0] pt);
    logic [63:0] w;
    w = pt;
    for (int i = 0; i < 32; i++)
      w = {w[47:0], w[63:48] ^ f_model(w[47:32], w[31:16], w[15:0], round_keys[i])};
    return w;
  endfunction

  // Stand-in key schedule; any fixed expansion serves for round-trip checks
  task automatic load_keys(input logic [127:0] key);
    logic [127:0] x;
    x = key;
    for (int i = 0; i < 32; i++) begin
      x = {x[116:0], x[127:117]} ^ {96'd0, 32'(i) * 32'h9E37_79B9};
      round_keys[i] = x[47:0] ^ x[127:80];
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [63:0] ct);
    int t;
    t = 0;
    @(negedge clk);
    while (!s_axis_tready && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", {63'd0, s_axis_tready}, 64'd1);
    s_axis_tdata  = ct;
    s_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!m_axis_tvalid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (s_axis_tready) busy_ok = 1'b0;
    end
  endtask

  task automatic run_block(input string name, input logic [127:0] key, input logic [63:0] pt);
    int   lat;
    logic busy_ok;
    load_keys(key);
    m_axis_tready = 1'b1;
    accept(encrypt(pt));
    wait_out(lat, busy_ok);
    check({name, "_latency"}, 64'(lat), 64'd32);
    check({name, "_data"}, m_axis_tdata, pt);
    check({name, "_busy"}, {63'd0, busy_ok}, 64'd1);
    @(posedge clk);
    #1;
    check({name, "_onecycle"}, {63'd0, m_axis_tvalid}, 64'd0);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int   lat;
    logic busy_ok, hold_ok, seen;
    logic [63:0] pt;

    tbl[0] = '{128'h0, 64'h0, 64'h0};
    tbl[1] = '{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    tbl[2] = '{128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[3] = '{128'h0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
    tbl[4] = '{128'hDEAD_BEEF_0000_0000_CAFE_F00D_1234_5678, 64'h0000_FFFF_0000_FFFF, 64'h0000_FFFF_0000_FFFF};

    rst = 1'b0;
    key_ready = 1'b1;
    s_axis_tdata = 64'd0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    load_keys(128'h0);
    #23;
    check("rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
    check("rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_m_tdata", m_axis_tdata, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      load_keys(tbl[i].key);
      m_axis_tready = 1'b1;
      accept(encrypt(tbl[i].pt));
      wait_out(lat, busy_ok);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd32);
      check($sformatf("tbl%0d_data", i), m_axis_tdata, tbl[i].exp);
      check($sformatf("tbl%0d_busy", i), {63'd0, busy_ok}, 64'd1);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_onecycle", i), {63'd0, m_axis_tvalid}, 64'd0);
      check($sformatf("tbl%0d_ready_back", i), {63'd0, s_axis_tready}, 64'd1);
    end

    for (int i = 0; i < 100; i++)
      run_block($sformatf("rnd%0d", i), {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});

    // key_ready low: ready stays low and a presented block is ignored
    @(negedge clk);
    key_ready = 1'b0;
    s_axis_tdata = 64'h1111_2222_3333_4444;
    s_axis_tvalid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (s_axis_tready || m_axis_tvalid) seen = 1'b1;
    end
    check("nokey_gate", {63'd0, seen}, 64'd0);
    s_axis_tvalid = 1'b0;
    key_ready = 1'b1;

    // backpressure: output held, then exactly one transfer
    load_keys(128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100);
    pt = 64'hA5A5_5A5A_C3C3_3C3C;
    m_axis_tready = 1'b0;
    accept(encrypt(pt));
    wait_out(lat, busy_ok);
    check("bp_latency", 64'(lat), 64'd32);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!m_axis_tvalid || m_axis_tdata !== pt || s_axis_tready) hold_ok = 1'b0;
    end
    check("bp_hold", {63'd0, hold_ok}, 64'd1);
    check("bp_data", m_axis_tdata, pt);
    @(negedge clk);
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {63'd0, m_axis_tvalid}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (m_axis_tvalid) seen = 1'b1;
    end
    check("bp_single", {63'd0, seen}, 64'd0);

    // abort at round 10 by dropping key_ready
    load_keys(128'h1);
    accept(encrypt(64'h7777_8888_9999_AAAA));
    repeat (10) @(posedge clk);
    @(negedge clk);
    key_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (m_axis_tvalid) seen = 1'b1;
    end
    check("abort_no_out", {63'd0, seen}, 64'd0);
    @(negedge clk);
    key_ready = 1'b1;
    #1;
    check("abort_idle", {63'd0, s_axis_tready}, 64'd1);
    run_block("after_abort", 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 64'h0123_4567_89AB_CDEF);

    // asynchronous reset in the middle of RUN
    load_keys(128'h2);
    accept(encrypt(64'h1234_5678_9ABC_DEF0));
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_s_tready", {63'd0, s_axis_tready}, 64'd0);
    check("midrst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("midrst_m_tdata", m_axis_tdata, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_block("after_rst", 128'h3, 64'hFEDC_BA98_7654_3210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decryption.md
Name: decryption

Overview:
- Iterative MacGuffin block decryptor. Inverse of the `encryption` block.
- Accepts a 64-bit ciphertext on an AXI-Stream slave. Applies the 32 rounds in reverse order, one round per clock, using the `round_keys` array produced by `key_setup`.
- Emits the 64-bit plaintext on an AXI-Stream master.
- Sits beside `encryption`, downstream of `key_setup`, sharing the same round-key bus.

Parameters:
- ROUNDS, 32, number of cipher rounds; also the depth of `round_keys`.
- KEY_W, 48, width of one round key (three 16-bit subkeys).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  64  ciphertext block.
- s_axis_tvalid  input  1  ciphertext valid.
- s_axis_tready  output  1  decryptor can accept a block.
- m_axis_tdata  output  64  plaintext block.
- m_axis_tvalid  output  1  plaintext valid.
- m_axis_tready  input  1  downstream accepts plaintext.
- round_keys  input  ROUNDS x KEY_W  round keys from `key_setup`; index 0 is the first encryption round.
- key_ready  input  1  `key_setup` has finished; `round_keys` are valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, round counter=ROUNDS-1, data register=0.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0.
- Word layout and round function F are identical to `encryption` (same S-boxes, same bit selection).
  - Block = W0..W3, 16 bits each. W0 is the word that receives F in encryption.
  - Encryption round: (W0,W1,W2,W3) -> (W1, W2, W3, W0 ^ F(W1,W2,W3,k)).
- Decryption round i: (W0,W1,W2,W3) -> (W3 ^ F(W0,W1,W2,round_keys[i]), W0, W1, W2).
  - Rounds run with i = ROUNDS-1 down to 0.
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - s_axis_tready = key_ready. This is the only state in which s_axis_tready may be 1.
  - On s_axis_tvalid & s_axis_tready at edge N: latch tdata, counter=ROUNDS-1, go to RUN.
- RUN:
  - One decryption round per edge, counter decrements.
  - Edges N+1..N+32 execute rounds 31..0.
  - The round with counter==0 goes to OUT.
  - s_axis_tready=0 throughout.
- OUT:
  - m_axis_tvalid=1 from edge N+32, i.e. 32 cycles after acceptance.
  - m_axis_tdata = data register.
  - tdata and tvalid are held stable until m_axis_tready=1.
  - On handshake: tvalid drops on that edge, go to IDLE. s_axis_tready may rise on the next cycle.
  - Minimum block interval is 34 cycles.
- No overlap: a second block is never accepted while RUN or OUT is active.
- key_ready=0 during RUN: abort the current block, go to IDLE, tvalid stays 0, block is discarded.
  - key_ready=0 during OUT has no effect; the result is already complete.
- key_ready=0 in IDLE: s_axis_tready=0; s_axis_tvalid is ignored.
- Asserting s_axis_tvalid and m_axis_tready in the same cycle is legal. Each handshake is evaluated only in its own state.
- Reset mid-operation: immediate return to reset values; the partial block is lost. The first block after reset is processed normally.
- `round_keys` must be stable while key_ready=1. The block samples `round_keys[counter]` combinationally each RUN cycle and does not store keys.

Test Plan:
- Round-trip: key 128'h0, plaintext 64'h0 through `encryption`, ciphertext into decryption -> m_axis_tdata = 64'h0.
- Round-trip: key 128'h00112233445566778899AABBCCDDEEFF, plaintext 64'h0123456789ABCDEF -> decrypted output = 64'h0123456789ABCDEF. Repeat for 100 random key/plaintext pairs against `encryption`, all matching.
- Latency/handshake: accept at edge N with m_axis_tready=1 -> m_axis_tvalid first high after edge N+32, one cycle wide. s_axis_tready low from N+1 until after the output handshake.
- Backpressure: m_axis_tready=0 for 10 cycles after tvalid -> tvalid and tdata unchanged throughout, s_axis_tready=0. After release, one transfer only.
- key_ready gating/abort:
  - key_ready=0 with s_axis_tvalid=1 -> s_axis_tready=0, no acceptance.
  - Drop key_ready at round 10 -> no output, FSM in IDLE. After key_ready returns, the next block decrypts correctly.
- Reset mid-RUN (rst=0 at round 15, asynchronous, between edges) -> outputs 0 immediately. A new block after release decrypts correctly with standard 32-cycle latency.
